pipe_stage_chain: RTL and testbench

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

---
 rtl/pipe_stage_chain.sv | 108 ++++++++++
 tb/tb_pipe_stage_chain.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// Valid/ready register pipeline with per-stage stall and flush, bubble collapse,
// a registered occupancy count and a retired-beat counter.
module pipe_stage_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    input  logic [STAGES-1:0]           stall,
    input  logic [STAGES-1:0]           flush,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    output logic [STAGES-1:0]           stage_valid,
    output logic [STAGES*WIDTH-1:0]     stage_data,
    output logic [$clog2(STAGES+1)-1:0] occupancy,
    output logic [31:0]                 retire_cnt
);

    localparam int OCC_W = $clog2(STAGES+1);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  data_q   [STAGES];
    logic [WIDTH-1:0]  data_d   [STAGES];
    logic [WIDTH-1:0]  src_data [STAGES];
    logic [OCC_W-1:0]  occ_d;
    logic              carry;

    // Advance ripples from the output back to stage 0; a scalar carry keeps
    // the chain free of vector self-reads.
    always_comb begin
        carry = out_ready;
        adv   = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i] = ~stall[i] & (~valid_q[i] | carry);
            carry  = adv[i];
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[STAGES-1] & ~stall[STAGES-1];
    assign out_data  = data_q[STAGES-1];

    always_comb begin
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int i = 1; i < STAGES; i++) begin
            // A stalled or flushed stage hands a bubble to its successor.
            src_valid[i] = valid_q[i-1] & ~stall[i-1] & ~flush[i-1];
            src_data[i]  = data_q[i-1];
        end
    end

    // NOTE: every variable gets a default before the priority chain so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            valid_d[i] = valid_q[i];
            data_d[i]  = data_q[i];
            if (flush[i]) begin
                valid_d[i] = 1'b0;
            end else if (adv[i]) begin
                valid_d[i] = src_valid[i];
                data_d[i]  = src_data[i];
            end
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage samples
    // its neighbour's pre-edge value; the data array is reset too because its
    // contents are visible on stage_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            occupancy  <= '0;
            retire_cnt <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            occupancy <= occ_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
            if (out_valid && out_ready) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        stage_valid = valid_q;
        stage_data  = '0;
        for (int i = 0; i < STAGES; i++) begin
            stage_data[i*WIDTH +: WIDTH] = data_q[i];
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (STAGES=4, WIDTH=32) with hand-computed
// expectations checked by immediate assertions.
module tb_pipe_stage_chain;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic [3:0]   stall;
    logic [3:0]   flush;
    logic         out_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [3:0]   stage_valid;
    logic [127:0] stage_data;
    logic [2:0]   occupancy;
    logic [31:0]  retire_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_chain #(.WIDTH(32), .STAGES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .stall      (stall),
        .flush      (flush),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .stage_valid(stage_valid),
        .stage_data (stage_data),
        .occupancy  (occupancy),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0;
        stall = '0; flush = '0; out_ready = 1'b1;
        step(); step();
        check("rst_valid", 128'(stage_valid), 128'h0);
        check("rst_occ", 128'(occupancy), 128'd0);
        check("rst_retire", 128'(retire_cnt), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_data", stage_data, 128'h0);
        reset = 1'b0;

        // Fill: 0x10 accepted at edge 1 reaches the output after edge 4.
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'h10 + 32'(k);
            step();
        end
        check("fill_out_valid", 128'(out_valid), 128'd1);
        check("fill_out_data", 128'(out_data), 128'h10);
        check("fill_occ", 128'(occupancy), 128'd4);
        in_data = 32'h14; step();
        check("fill_out_data2", 128'(out_data), 128'h11);
        check("fill_retire1", 128'(retire_cnt), 128'd1);
        in_data = 32'h15; step();
        check("fill_out_data3", 128'(out_data), 128'h12);
        check("fill_retire2", 128'(retire_cnt), 128'd2);

        // Backpressure for three cycles: everything frozen.
        out_ready = 1'b0; in_data = 32'h16;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 128'(in_ready), 128'd0);
            step();
            check("bp_valid", 128'(stage_valid), 128'hF);
            check("bp_data", stage_data, {32'h12, 32'h13, 32'h14, 32'h15});
            check("bp_retire", 128'(retire_cnt), 128'd2);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("drain_d13", 128'(out_data), 128'h13);
        check("drain_r3", 128'(retire_cnt), 128'd3);
        step();
        check("drain_d14", 128'(out_data), 128'h14);
        step();
        check("drain_d15", 128'(out_data), 128'h15);
        check("drain_r5", 128'(retire_cnt), 128'd5);
        step();
        check("drain_empty", 128'(stage_valid), 128'h0);
        check("drain_r6", 128'(retire_cnt), 128'd6);
        check("drain_occ", 128'(occupancy), 128'd0);

        // Build the 1010 pattern under backpressure.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA1; step();
        in_valid = 1'b0; step();
        in_valid = 1'b1; in_data = 32'hA2; step();
        in_valid = 1'b0; step();
        check("bub_pattern", 128'(stage_valid), 128'hA);
        check("bub_out_valid", 128'(out_valid), 128'd1);
        in_valid = 1'b1; in_data = 32'hAA;
        #1;
        check("bub_in_ready", 128'(in_ready), 128'd1);
        step();
        // Only one beat enters, so the stage-1 bubble moves up one slot.
        check("bub_valid", 128'(stage_valid), 128'hD);
        check("bub_data0", 128'(stage_data[31:0]), 128'hAA);
        check("bub_data3", 128'(stage_data[127:96]), 128'hA1);
        check("bub_occ", 128'(occupancy), 128'd3);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("bub_out_a2", 128'(out_data), 128'hA2);
        step();
        check("bub_gap", 128'(out_valid), 128'd0);
        step();
        check("bub_out_aa", 128'(out_data), 128'hAA);
        step();
        check("bub_retire", 128'(retire_cnt), 128'd9);
        check("bub_empty", 128'(stage_valid), 128'h0);

        // Stall stage 1 for one cycle in full flow.
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'h30 + 32'(k);
            step();
        end
        in_data = 32'h34; stall = 4'b0010;
        #1;
        check("stall_in_ready", 128'(in_ready), 128'd0);
        check("stall_out_valid", 128'(out_valid), 128'd1);
        step();
        check("stall_valid", 128'(stage_valid), 128'hB);
        check("stall_hold", 128'(stage_data[63:0]), 128'h00000032_00000033);
        check("stall_out", 128'(out_data), 128'h31);
        check("stall_retire", 128'(retire_cnt), 128'd10);
        stall = 4'b0000;
        step();
        check("stall_rel_valid", 128'(stage_valid), 128'h7);
        in_valid = 1'b0;
        step();
        check("stall_out32", 128'(out_data), 128'h32);
        check("stall_out32_v", 128'(out_valid), 128'd1);
        step();
        check("stall_out33", 128'(out_data), 128'h33);
        step();
        check("stall_out34", 128'(out_data), 128'h34);
        step();
        check("stall_retire_end", 128'(retire_cnt), 128'd14);
        check("stall_empty", 128'(stage_valid), 128'h0);

        // Flush the two upstream stages of a full pipe.
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'h20 + 32'(k);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 4'b0011;
        step();
        check("flush_valid", 128'(stage_valid), 128'hC);
        check("flush_occ", 128'(occupancy), 128'd2);
        check("flush_data", stage_data, {32'h20, 32'h21, 32'h22, 32'h23});

        // A beat accepted while flush[0] is set is dropped.
        in_valid = 1'b1; in_data = 32'h55; flush = 4'b0001;
        #1;
        check("flush0_in_ready", 128'(in_ready), 128'd1);
        step();
        check("flush0_valid", 128'(stage_valid), 128'hC);

        // Stall and flush together still invalidate the stage.
        in_valid = 1'b0; flush = 4'b0100; stall = 4'b0100;
        step();
        check("stall_flush_valid", 128'(stage_valid), 128'h8);
        check("stall_flush_occ", 128'(occupancy), 128'd1);
        flush = '0; stall = '0;

        // Reset mid-stream discards everything and clears the counter.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'h40 + 32'(k);
            step();
        end
        check("pre_rst_retire", 128'(retire_cnt), 128'd15);
        check("pre_rst_valid", 128'(stage_valid), 128'hF);
        reset = 1'b1;
        step();
        check("mid_rst_valid", 128'(stage_valid), 128'h0);
        check("mid_rst_occ", 128'(occupancy), 128'd0);
        check("mid_rst_retire", 128'(retire_cnt), 128'd0);
        check("mid_rst_in_ready", 128'(in_ready), 128'd1);
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        reset = 1'b0; in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
